// File: rtl/dircc_avalon_st_packet_arbiter.sv
// Packet-granular round-robin arbiter: NUM_INPUTS Avalon-ST sources share one
// Avalon-ST sink. A granted source owns the output until its EOP beat
// transfers. A small Avalon-MM status slave reports grant state, a sticky
// protocol-error flag and a packet counter, both clear-on-read.
module dircc_avalon_st_packet_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_INPUTS = 4,
    parameter int GRANT_W    = 3
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_INPUTS*2-1:0]          in_empty,
    input  logic [NUM_INPUTS-1:0]            in_startofpacket,
    input  logic [NUM_INPUTS-1:0]            in_endofpacket,
    input  logic [NUM_INPUTS-1:0]            in_valid,
    output logic [NUM_INPUTS-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [1:0]                       out_empty,
    output logic                             out_startofpacket,
    output logic                             out_endofpacket,
    output logic                             out_valid,
    input  logic                             out_ready,
    input  logic                             address,
    output logic [15:0]                      readdata,
    input  logic                             read_n
);

    localparam int unsigned NI = NUM_INPUTS;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [GRANT_W-1:0] grant;
    logic [GRANT_W-1:0] rr_ptr;
    logic [GRANT_W-1:0] arb_idx;
    logic [GRANT_W-1:0] grant_inc;
    logic               first_beat;
    logic               beat_xfer;
    logic               eop_xfer;
    logic               proto_err;
    logic               err;
    logic [15:0]        pkt_count;
    logic               rd_status;
    logic               rd_count;

    // Round-robin pick: lowest valid index at or above rr_ptr, else lowest valid index (wrap)
    always_comb begin
        logic [GRANT_W-1:0] arb_hi;
        logic [GRANT_W-1:0] arb_lo;
        logic               found_hi;
        logic               found_lo;
        arb_hi   = '0;
        arb_lo   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int unsigned i = 0; i < NI; i++) begin
            if (in_valid[i]) begin
                if (!found_lo) begin
                    arb_lo   = GRANT_W'(i);
                    found_lo = 1'b1;
                end
                if (!found_hi && (GRANT_W'(i) >= rr_ptr)) begin
                    arb_hi   = GRANT_W'(i);
                    found_hi = 1'b1;
                end
            end
        end
        arb_idx = found_hi ? arb_hi : arb_lo;
    end

    assign grant_inc = (grant == GRANT_W'(NUM_INPUTS - 1)) ? '0 : grant + 1'b1;
    assign beat_xfer = out_valid & out_ready;
    assign eop_xfer  = beat_xfer & out_endofpacket;
    assign proto_err = beat_xfer & first_beat & ~out_startofpacket;
    assign rd_status = ~read_n & ~address;
    assign rd_count  = ~read_n & address;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: one arbitration cycle in IDLE, hold LOCKED until the EOP beat transfers
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|in_valid) state_next = LOCKED;
            LOCKED:  if (eop_xfer)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output path: combinational mux from the granted source while LOCKED, all zero in IDLE
    always_comb begin
        in_ready          = '0;
        out_data          = '0;
        out_empty         = '0;
        out_startofpacket = 1'b0;
        out_endofpacket   = 1'b0;
        out_valid         = 1'b0;
        if (state == LOCKED) begin
            for (int unsigned i = 0; i < NI; i++) begin
                if (grant == GRANT_W'(i)) begin
                    out_data          = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                    out_empty         = in_empty[i*2 +: 2];
                    out_startofpacket = in_startofpacket[i];
                    out_endofpacket   = in_endofpacket[i];
                    out_valid         = in_valid[i];
                    in_ready[i]       = out_ready;
                end
            end
        end
    end

    // Grant, round-robin pointer and first-beat tracking
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            grant      <= '0;
            rr_ptr     <= '0;
            first_beat <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (|in_valid) begin
                    grant      <= arb_idx;
                    first_beat <= 1'b1;
                end
            end else if (beat_xfer) begin
                first_beat <= 1'b0;
                if (out_endofpacket) begin
                    rr_ptr <= grant_inc;
                end
            end
        end
    end

    // Status slave: sticky error and packet counter with clear-on-read; a same-cycle event wins over the clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err       <= 1'b0;
            pkt_count <= '0;
            readdata  <= '0;
        end else begin
            if (proto_err) begin
                err <= 1'b1;
            end else if (rd_status) begin
                err <= 1'b0;
            end

            if (rd_count) begin
                pkt_count <= eop_xfer ? 16'd1 : 16'd0;
            end else if (eop_xfer) begin
                pkt_count <= pkt_count + 16'd1;
            end

            if (!read_n) begin
                if (address) begin
                    readdata <= pkt_count;
                end else begin
                    readdata <= {state == LOCKED, err, {(14 - GRANT_W){1'b0}}, grant};
                end
            end
        end
    end

endmodule
